// File: rtl/accumulate_sched_pkg.sv
// accumulate_sched_pkg: shared FSM state type and ID-width helper for the accumulate scheduler
package accumulate_sched_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT} state_t;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req bit at or after ptr (req[N], ptr -> gnt_onehot[N], gnt_idx, any)
module rr_arbiter import accumulate_sched_pkg::*; #(
  parameter int N = 4,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  int j;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt_idx = W'(j);
        any = 1'b1;
      end
    end
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/accumulate_scheduler.sv
// accumulate_scheduler: round-robin time-sharing of one stream accumulator among NREQ vector producers (clk, rst, req_valid/req_data/req_ready, acc_in_valid/acc_a, acc_out_valid/acc_c, res_valid/res_data/res_id, err/err_id)
module accumulate_scheduler import accumulate_sched_pkg::*; #(
  parameter int BITS    = 8,
  parameter int LENGTH  = 10,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8,
  localparam int IW = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 acc_in_valid,
  output logic [BITS-1:0]      acc_a,
  input  logic                 acc_out_valid,
  input  logic [BITS-1:0]      acc_c,
  output logic                 res_valid,
  output logic [BITS-1:0]      res_data,
  output logic [IW-1:0]        res_id,
  output logic                 err,
  output logic [IW-1:0]        err_id
);
  localparam int CW = $clog2(LENGTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic [IW-1:0] grant, ptr, nxt_ptr, arb_idx;
  logic [NREQ-1:0] grant_oh, arb_onehot;
  logic arb_any, cur_valid;
  logic [BITS-1:0] cur_data;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt_onehot(arb_onehot),
    .gnt_idx(arb_idx),
    .any(arb_any)
  );
  assign cur_valid = req_valid[grant];
  assign cur_data = req_data[BITS*int'(grant) +: BITS];
  assign nxt_ptr = grant == IW'(NREQ - 1) ? '0 : grant + 1'b1;
  assign req_ready = state == STREAM ? grant_oh : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_oh <= '0;
      ptr <= '0;
      cnt <= '0;
      tcnt <= '0;
      acc_in_valid <= 1'b0;
      acc_a <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
      err <= 1'b0;
      err_id <= '0;
    end else begin
      acc_in_valid <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      err <= 1'b0;
      case (state)
        IDLE: if (arb_any) begin
          grant <= arb_idx;
          grant_oh <= arb_onehot;
          cnt <= '0;
          state <= STREAM;
        end
        STREAM: if (cur_valid) begin
          acc_in_valid <= 1'b1;
          acc_a <= cur_data;
          if (cnt == CW'(LENGTH - 1)) begin
            cnt <= '0;
            tcnt <= '0;
            state <= WAIT_RESULT;
          end else cnt <= cnt + 1'b1;
        end else if (cnt != '0) begin
          // a gap would silently restart the accumulator's count, so the vector is unusable
          err <= 1'b1;
          err_id <= grant;
          ptr <= nxt_ptr;
          cnt <= '0;
          state <= IDLE;
        end
        WAIT_RESULT: if (acc_out_valid) begin
          res_valid <= 1'b1;
          res_data <= acc_c;
          res_id <= grant;
          ptr <= nxt_ptr;
          state <= IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err <= 1'b1;
          err_id <= grant;
          ptr <= nxt_ptr;
          state <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulate_scheduler.sv
// tb_accumulate_scheduler: scoreboard bench for accumulate_scheduler with a behavioural stream accumulator
module tb_accumulate_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready;
  logic acc_in_valid, acc_out_valid, acc_ov, res_valid, err;
  logic mute = 1'b0;
  logic [7:0] acc_a, acc_c, res_data, asum;
  logic [3:0] acnt;
  logic [1:0] res_id, err_id;
  int errors = 0;
  int checks = 0;
  typedef struct {bit is_err; int id; int data;} exp_t;
  exp_t sb[$];
  accumulate_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .acc_in_valid(acc_in_valid), .acc_a(acc_a),
    .acc_out_valid(acc_out_valid), .acc_c(acc_c),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .err(err), .err_id(err_id)
  );
  // accumulator: restarts whenever in_valid drops, emits the sum after ten elements
  always_ff @(posedge clk) begin
    if (rst || !acc_in_valid) begin
      acnt <= '0;
      asum <= '0;
      acc_ov <= 1'b0;
    end else if (acnt == 4'd9) begin
      acc_ov <= 1'b1;
      acc_c <= asum + acc_a;
      acnt <= '0;
      asum <= '0;
    end else begin
      acc_ov <= 1'b0;
      asum <= asum + acc_a;
      acnt <= acnt + 1'b1;
    end
  end
  assign acc_out_valid = acc_ov & ~mute;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic want(input bit is_err, input int id, input int data);
    exp_t e;
    e.is_err = is_err;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask
  task automatic drive(input int id, input int v0, input int step, input int gap);
    int i = 0;
    int g = 0;
    req_data[id*8 +: 8] = 8'(v0);
    req_valid[id] = 1'b1;
    while (i < 10 && i != gap && g < 300) begin
      @(negedge clk);
      g++;
      if (req_ready[id]) begin
        @(posedge clk);
        #1;
        i++;
        req_data[id*8 +: 8] = 8'(v0 + step * i);
      end
    end
    req_valid[id] = 1'b0;
    if (g >= 300) check("stall", i, 10);
  endtask
  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_acc_v"}, acc_in_valid, 0);
    check({tag, "_acc_a"}, acc_a, 0);
    check({tag, "_res_v"}, res_valid, 0);
    check({tag, "_res_d"}, res_data, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_id"}, err_id, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (res_valid || err)) begin
      if (sb.size() == 0) check("unexpected", {res_valid, err}, 0);
      else begin
        e = sb.pop_front();
        check("kind", err, e.is_err);
        check("id", err ? err_id : res_id, e.id);
        if (!e.is_err) check("sum", res_data, e.data);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check_quiet("rst");
    rst = 1'b0;
    want(0, 0, 55);
    drive(0, 1, 1, -1);
    drain();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) want(0, k, 10 * (k + 1));
    fork
      drive(0, 1, 0, -1);
      drive(1, 2, 0, -1);
      drive(2, 3, 0, -1);
      drive(3, 4, 0, -1);
    join
    drain();
    for (int j = 0; j < 3; j++) begin
      want(0, 1, 10 * (j + 1));
      want(0, 3, 10 * (j + 11));
    end
    fork
      for (int j = 0; j < 3; j++) drive(1, j + 1, 0, -1);
      for (int j = 0; j < 3; j++) drive(3, j + 11, 0, -1);
    join
    drain();
    want(1, 2, 0);
    drive(2, 9, 0, 4);
    drain();
    want(0, 2, 50);
    drive(2, 5, 0, -1);
    drain();
    want(0, 0, 44);
    drive(0, 30, 0, -1);
    drain();
    mute = 1'b1;
    want(1, 1, 0);
    drive(1, 1, 0, -1);
    drain();
    mute = 1'b0;
    drive(0, 7, 0, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("midrst");
    rst = 1'b0;
    want(0, 0, 10);
    drive(0, 1, 0, -1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
